// File: rtl/dcc_packet_gen.sv
// DCC packet generator with integrated bit encoder: preamble, start/data/error bytes, end bit.
// Sends the standard idle packet whenever no command is waiting in the holding register.
module dcc_packet_gen #(
  parameter int unsigned ONE_HALF_CYC  = 2900,
  parameter int unsigned ZERO_HALF_CYC = 5000,
  parameter int unsigned PREAMBLE_BITS = 14,
  parameter int unsigned MAX_BYTES     = 6,
  parameter int unsigned IDX_W         = 10
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [$clog2(MAX_BYTES+1)-1:0] cmd_len,
  input  logic [8*MAX_BYTES-1:0]         cmd_data,
  output logic [IDX_W-1:0]               cmd_index,
  output logic                           track_out,
  output logic                           pkt_done,
  output logic                           idle_pkt
);
  localparam int unsigned LEN_W  = $clog2(MAX_BYTES+1);
  localparam int unsigned DATA_W = 8*MAX_BYTES;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {S_PRE, S_START, S_DATA, S_END} state_t;

  state_t            state_q, state_d;
  logic [7:0]        pre_cnt_q, pre_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0]  byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0]  n_bytes_q, n_bytes_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              hold_full_q, hold_full_d;
  logic [LEN_W-1:0]  hold_len_q, hold_len_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]  half_cnt_q, half_cnt_d;
  logic              high_q, high_d;
  logic              cur_one_q, cur_one_d;
  logic              running_q, running_d;
  logic              track_d, pkt_done_d, idle_d, cmd_ready_d;
  logic [IDX_W-1:0]  cmd_index_d;

  logic              accept_c, sel_full_c, load_c, bit_c;
  logic [LEN_W-1:0]  sel_len_c, clamp_len_c;
  logic [DATA_W-1:0] sel_data_c;
  logic [7:0]        err_c, byte_c;

  // Error byte and the byte currently on the wire (byte index n_bytes is the error byte)
  always_comb begin
    err_c  = 8'h00;
    byte_c = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (LEN_W'(k) < n_bytes_q)   err_c  = err_c ^ tx_buf_q[8*k +: 8];
      if (LEN_W'(k) == byte_idx_q) byte_c = tx_buf_q[8*k +: 8];
    end
    if (byte_idx_q == n_bytes_q) byte_c = err_c;
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    n_bytes_d   = n_bytes_q;
    tx_buf_d    = tx_buf_q;
    hold_full_d = hold_full_q;
    hold_len_d  = hold_len_q;
    hold_data_d = hold_data_q;
    half_cnt_d  = half_cnt_q;
    high_d      = high_q;
    cur_one_d   = cur_one_q;
    running_d   = running_q;
    track_d     = track_out;
    pkt_done_d  = 1'b0;
    idle_d      = idle_pkt;
    cmd_index_d = cmd_index;
    load_c      = 1'b0;
    bit_c       = 1'b1;

    accept_c    = cmd_valid & ~hold_full_q;
    sel_full_c  = hold_full_q | accept_c;
    sel_len_c   = hold_full_q ? hold_len_q : cmd_len;
    sel_data_c  = hold_full_q ? hold_data_q : cmd_data;
    clamp_len_c = (sel_len_c > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len_c;

    if (accept_c) begin
      hold_full_d = 1'b1;
      hold_len_d  = cmd_len;
      hold_data_d = cmd_data;
      cmd_index_d = cmd_index + IDX_W'(1);
    end

    if (!running_q) begin
      running_d = 1'b1;
      state_d   = S_PRE;
      pre_cnt_d = 8'd0;
      idle_d    = ~hold_full_q;
      load_c    = 1'b1;
    end else if (half_cnt_q != '0) begin
      half_cnt_d = half_cnt_q - CNT_W'(1);
    end else if (high_q) begin
      track_d    = 1'b0;
      high_d     = 1'b0;
      half_cnt_d = cur_one_q ? CNT_W'(ONE_HALF_CYC - 1) : CNT_W'(ZERO_HALF_CYC - 1);
    end else begin
      // Bit boundary: advance framing, then load the next bit
      load_c = 1'b1;
      case (state_q)
        S_PRE: begin
          if (pre_cnt_q == 8'(PREAMBLE_BITS - 1)) begin
            state_d    = S_START;
            byte_idx_d = '0;
            if (sel_full_c) hold_full_d = 1'b0;
            if (sel_full_c && sel_len_c != '0) begin
              tx_buf_d  = sel_data_c;
              n_bytes_d = clamp_len_c;
              idle_d    = 1'b0;
            end else begin
              tx_buf_d  = DATA_W'(16'h00FF);
              n_bytes_d = LEN_W'(2);
              idle_d    = 1'b1;
            end
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end
        S_START: begin
          state_d   = S_DATA;
          bit_idx_d = 3'd7;
        end
        S_DATA: begin
          if (bit_idx_q == 3'd0) begin
            if (byte_idx_q == n_bytes_q) begin
              state_d = S_END;
            end else begin
              state_d    = S_START;
              byte_idx_d = byte_idx_q + LEN_W'(1);
            end
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end
        default: begin
          state_d    = S_PRE;
          pre_cnt_d  = 8'd0;
          pkt_done_d = 1'b1;
          idle_d     = ~hold_full_q;
        end
      endcase
    end

    if (load_c) begin
      case (state_d)
        S_START: bit_c = 1'b0;
        S_DATA:  bit_c = byte_c[bit_idx_d];
        default: bit_c = 1'b1;
      endcase
      track_d    = 1'b1;
      high_d     = 1'b1;
      cur_one_d  = bit_c;
      half_cnt_d = bit_c ? CNT_W'(ONE_HALF_CYC - 1) : CNT_W'(ZERO_HALF_CYC - 1);
    end

    cmd_ready_d = ~hold_full_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PRE;
      pre_cnt_q   <= 8'd0;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= '0;
      n_bytes_q   <= '0;
      tx_buf_q    <= '0;
      hold_full_q <= 1'b0;
      hold_len_q  <= '0;
      hold_data_q <= '0;
      half_cnt_q  <= '0;
      high_q      <= 1'b0;
      cur_one_q   <= 1'b0;
      running_q   <= 1'b0;
      track_out   <= 1'b0;
      pkt_done    <= 1'b0;
      idle_pkt    <= 1'b0;
      cmd_ready   <= 1'b1;
      cmd_index   <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      n_bytes_q   <= n_bytes_d;
      tx_buf_q    <= tx_buf_d;
      hold_full_q <= hold_full_d;
      hold_len_q  <= hold_len_d;
      hold_data_q <= hold_data_d;
      half_cnt_q  <= half_cnt_d;
      high_q      <= high_d;
      cur_one_q   <= cur_one_d;
      running_q   <= running_d;
      track_out   <= track_d;
      pkt_done    <= pkt_done_d;
      idle_pkt    <= idle_d;
      cmd_ready   <= cmd_ready_d;
      cmd_index   <= cmd_index_d;
    end
  end
endmodule

// File: doc/dcc_packet_gen.md
Name: dcc_packet_gen

Overview:
Parametrised DCC packet generator with an integrated bit encoder. It transmits variable-length packets (1..MAX_BYTES data bytes plus an XOR error byte) with a configurable preamble. Packets are taken from a one-entry command register loaded over a valid/ready handshake. When no command is pending, it emits the standard DCC idle packet, so the track is never silent. It sits between the command store/sequencer and the track driver.

Parameters:
ONE_HALF_CYC, 2900, clk cycles per half-period of a '1' bit (58 us at 50 MHz)
ZERO_HALF_CYC, 5000, clk cycles per half-period of a '0' bit (100 us at 50 MHz); must be > ONE_HALF_CYC
PREAMBLE_BITS, 14, number of '1' bits in each preamble; legal range 10..255
MAX_BYTES, 6, maximum data bytes per packet, excluding the error byte
IDX_W, 10, width of cmd_index

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present on cmd_len/cmd_data
cmd_ready  out  1  holding register empty; command accepted when cmd_valid & cmd_ready at a clk edge
cmd_len  in  clog2(MAX_BYTES+1)  number of data bytes
cmd_data  in  8*MAX_BYTES  byte k on [8k+7:8k]; byte 0 is sent first
cmd_index  out  IDX_W  count of accepted commands, wraps modulo 2^IDX_W
track_out  out  1  encoded DCC bitstream
pkt_done  out  1  one-cycle pulse at the end of each packet's end bit
idle_pkt  out  1  high for the whole packet (preamble included) when the packet being sent is the idle packet

Behaviour:
- Reset (async, reset_n=0):
  - track_out=0, cmd_ready=1, cmd_index=0, pkt_done=0, idle_pkt=0.
  - Holding register cleared; FSM goes to PREAMBLE with bit count 0.
  - Reset mid-packet aborts the packet immediately; no partial completion and no pkt_done.
- Bit encoding:
  - Each bit is a high half followed by a low half of equal length.
  - Half length is ONE_HALF_CYC for '1' and ZERO_HALF_CYC for '0'.
  - track_out rises in the first cycle after reset deassertion and at every bit boundary thereafter. Bits are gapless.
- Internal half-period counter: 16 bits, counts down. The next bit is loaded on the cycle the low half expires.
- FSM:
  - PREAMBLE: sends PREAMBLE_BITS '1's.
  - START: sends one '0'.
  - DATA: sends 8 bits, MSB first.
  - Transitions:
    - START/DATA repeats for each data byte, then once more for the error byte.
    - Then END sends one '1' → PREAMBLE.
- Packet selection happens at the final bit boundary of the preamble:
  - If the holding register is full: its bytes are latched into the transmit buffer, the holding register is cleared (cmd_ready=1 next cycle), and idle_pkt=0.
  - Otherwise the idle packet (0xFF, 0x00) is sent. idle_pkt is registered at the start of the preamble from the holding-register state at that moment and re-evaluated at selection.
- Error byte: XOR of all transmitted data bytes, computed from the latched buffer.
- cmd_len rules:
  - cmd_len=0 is treated as an idle packet, but the command is still consumed and cmd_index still increments.
  - cmd_len>MAX_BYTES is clamped to MAX_BYTES.
- Handshake:
  - cmd_ready=!full.
  - Acceptance sets full and increments cmd_index in the same edge.
  - Acceptance and selection in the same cycle: the register is full at selection, so the new command is sent.
  - cmd_data is not required to be stable after acceptance.
- pkt_done: asserted in the cycle the END bit's low half expires; the coinciding next preamble bit starts then.
- Packet length in bits: PREAMBLE_BITS + 9*(n+1) + 1, where n = number of data bytes.

Test Plan:
(Bench parameters: ONE_HALF_CYC=2, ZERO_HALF_CYC=4, PREAMBLE_BITS=14, MAX_BYTES=4.)
- No command after reset → stream 14×'1', 0, 11111111, 0, 00000000, 0, 11111111, 1 (42 bits); idle_pkt=1; pkt_done once; first '1' high exactly 2 cycles, low 2 cycles.
- Command len=2, data 0x03, 0x3F, accepted during idle preamble → next packet carries 03, 3F, error 0x3C; cmd_index=1; cmd_ready returns 1 after selection.
- Commands len=3 (C1, 23, 45) then len=4 (01, 02, 04, 08), held valid → both sent back to back in order; error bytes 0xA7 and 0x0F; cmd_ready low between acceptance and selection.
- cmd_len=0 → idle packet sent, cmd_index increments; cmd_len=7 with data 11, 22, 44, 88 in bytes 0..3 → 4 bytes sent, error 0xFF.
- reset_n pulsed low mid-DATA for 1 cycle → track_out=0 asynchronously; no pkt_done; restart with a full preamble, cmd_index=0, pending command discarded.
- Command accepted in exactly the preamble-final-bit cycle → sent in that packet, not the following one.
